// File: rtl/dmem_access_seq.sv
// Load/store sequencer between the CPU memory stage and a word-wide
// synchronous-read data memory. Buffers each request, stalls the CPU while
// the access is in flight, does read-modify-write for sub-word stores and
// returns sign- or zero-extended load data.
module dmem_access_seq #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       addr,
  input  logic [31:0]       write_data,
  input  logic              memwrite,
  input  logic              memread,
  input  logic [3:0]        sign_mask,
  output logic [31:0]       read_data,
  output logic              clk_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, DONE} state_t;

  state_t            state, next_state;
  logic [ADDR_W+1:0] addr_buf;
  logic [31:0]       wdata_buf;
  logic [3:0]        mask_buf;
  logic [31:0]       merged_buf;
  logic [31:0]       load_fmt;
  logic [31:0]       merge_word;
  logic [7:0]        lane_byte;
  logic [15:0]       lane_half;
  logic              unused_addr_hi;

  // Address bits above the memory's reach alias onto the same words.
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  // The memory sees the live CPU address while idle so the read can be
  // launched in the same cycle the request appears.
  assign mem_addr  = (state == IDLE) ? addr[ADDR_W+1:2] : addr_buf[ADDR_W+1:2];
  assign mem_wdata = mask_buf[2] ? wdata_buf : merged_buf;

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    lane_byte  = 8'h00;
    lane_half  = addr_buf[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_fmt   = mem_rdata;
    merge_word = mem_rdata;
    case (addr_buf[1:0])
      2'd0:    lane_byte = mem_rdata[7:0];
      2'd1:    lane_byte = mem_rdata[15:8];
      2'd2:    lane_byte = mem_rdata[23:16];
      default: lane_byte = mem_rdata[31:24];
    endcase
    if (mask_buf[2]) begin
      load_fmt = mem_rdata;
    end else if (mask_buf[1]) begin
      load_fmt = {{16{mask_buf[3] & lane_half[15]}}, lane_half};
    end else begin
      load_fmt = {{24{mask_buf[3] & lane_byte[7]}}, lane_byte};
    end
    if (mask_buf[1]) begin
      if (addr_buf[1]) merge_word[31:16] = wdata_buf[15:0];
      else             merge_word[15:0]  = wdata_buf[15:0];
    end else begin
      case (addr_buf[1:0])
        2'd0:    merge_word[7:0]   = wdata_buf[7:0];
        2'd1:    merge_word[15:8]  = wdata_buf[7:0];
        2'd2:    merge_word[23:16] = wdata_buf[7:0];
        default: merge_word[31:24] = wdata_buf[7:0];
      endcase
    end
  end

  // Next-state and control outputs; reset forces the strobes and stall low.
  always_comb begin
    next_state = state;
    clk_stall  = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    case (state)
      IDLE: begin
        if (memwrite) begin
          clk_stall = 1'b1;
          if (sign_mask[2]) begin
            next_state = WR;
          end else begin
            mem_re     = 1'b1;
            next_state = RMW_RD;
          end
        end else if (memread) begin
          clk_stall  = 1'b1;
          mem_re     = 1'b1;
          next_state = RD;
        end
      end
      RD: begin
        clk_stall  = 1'b1;
        next_state = DONE;
      end
      RMW_RD: begin
        clk_stall  = 1'b1;
        next_state = WR;
      end
      WR: begin
        clk_stall  = 1'b1;
        mem_we     = 1'b1;
        next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (!rst_n) begin
      clk_stall = 1'b0;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
    end
  end

  // State register, request buffers, merged word and load result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_buf   <= '0;
      wdata_buf  <= '0;
      mask_buf   <= '0;
      merged_buf <= '0;
      read_data  <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && (memwrite || memread)) begin
        addr_buf  <= addr[ADDR_W+1:0];
        wdata_buf <= write_data;
        mask_buf  <= sign_mask;
      end
      if (state == RD)     read_data  <= load_fmt;
      if (state == RMW_RD) merged_buf <= merge_word;
    end
  end

endmodule

// File: tb/tb_dmem_access_seq.sv
// Directed bench for dmem_access_seq with a behavioural EBR model and a
// scoreboard of expected memory writes and load results.
module tb_dmem_access_seq;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        memwrite;
  logic        memread;
  logic [3:0]  sign_mask;
  logic [31:0] read_data;
  logic        clk_stall;
  logic [9:0]  mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  typedef struct packed {
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;

  logic [31:0] mem [0:1023];
  wr_t         wrQ[$];
  logic [31:0] rdQ[$];
  int          checkCount = 0;
  int          passCount  = 0;
  int          reCount    = 0;
  int          weCount    = 0;

  dmem_access_seq #(.ADDR_W(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr       (addr),
    .write_data (write_data),
    .memwrite   (memwrite),
    .memread    (memread),
    .sign_mask  (sign_mask),
    .read_data  (read_data),
    .clk_stall  (clk_stall),
    .mem_addr   (mem_addr),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read, one-cycle-latency memory.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Memory-side monitor: strobe exclusivity and scoreboarded writes.
  always @(negedge clk) begin
    if (mem_re) reCount++;
    if (mem_re || mem_we) checkOutput("re_we_exclusive", {31'b0, mem_re & mem_we}, 32'h0);
    if (mem_we) begin
      weCount++;
      if (wrQ.size() == 0) begin
        checkOutput("unexpected_we", {31'b0, mem_we}, 32'h0);
      end else begin
        wr_t e;
        e = wrQ.pop_front();
        checkOutput("we_addr", {22'b0, mem_addr}, {22'b0, e.a});
        checkOutput("we_data", mem_wdata, e.d);
      end
    end
  end

  task automatic applyStimulus(input string tag, input logic rd, input logic wr,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [3:0] m, input int expStall,
                               input int expRe, input int expWe,
                               input logic [9:0] expAddr, input logic [31:0] expWord);
    int  stalls;
    bit  isLoad;
    wr_t e;
    logic [31:0] expRd;
    @(posedge clk);
    #1;
    isLoad = rd && !wr;
    if (wr) begin
      e.a = expAddr;
      e.d = expWord;
      wrQ.push_back(e);
    end else begin
      rdQ.push_back(expWord);
    end
    reCount    = 0;
    weCount    = 0;
    memread    = rd;
    memwrite   = wr;
    addr       = a;
    write_data = wd;
    sign_mask  = m;
    #1;
    checkOutput({tag, "_mem_addr"}, {22'b0, mem_addr}, {22'b0, expAddr});
    stalls = 0;
    forever begin
      @(negedge clk);
      if (!clk_stall) break;
      stalls++;
      if (stalls > 10) begin
        checkOutput({tag, "_timeout"}, {31'b0, clk_stall}, 32'h0);
        break;
      end
    end
    memread  = 1'b0;
    memwrite = 1'b0;
    checkOutput({tag, "_stalls"}, stalls, expStall);
    if (isLoad) begin
      expRd = rdQ.pop_front();
      checkOutput({tag, "_read_data"}, read_data, expRd);
    end
    checkOutput({tag, "_re_count"}, reCount, expRe);
    checkOutput({tag, "_we_count"}, weCount, expWe);
  endtask

  // Directed sequence.
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem_rdata  = 32'h0;
    rst_n      = 1'b0;
    memread    = 1'b1;
    memwrite   = 1'b0;
    addr       = 32'h0;
    write_data = 32'h0;
    sign_mask  = 4'b0111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_stall", {31'b0, clk_stall}, 32'h0);
    checkOutput("rst_re", {31'b0, mem_re}, 32'h0);
    checkOutput("rst_we", {31'b0, mem_we}, 32'h0);
    checkOutput("rst_read_data", read_data, 32'h0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    memread = 1'b0;
    @(negedge clk);
    checkOutput("idle_stall", {31'b0, clk_stall}, 32'h0);
    checkOutput("idle_re", {31'b0, mem_re}, 32'h0);

    $display("[TB] stores");
    mem[4] = 32'h0BAD0BAD;
    applyStimulus("word_st", 1'b0, 1'b1, 32'h010, 32'hDEADBEEF, 4'b0111, 2, 0, 1, 10'd4, 32'hDEADBEEF);
    mem[4] = 32'h11223344;
    applyStimulus("byte_st", 1'b0, 1'b1, 32'h012, 32'h000000AA, 4'b0001, 3, 1, 1, 10'd4, 32'h11AA3344);
    checkOutput("byte_st_mem", mem[4], 32'h11AA3344);
    checkOutput("st_keeps_read_data", read_data, 32'h0);
    mem[5] = 32'hCAFEF00D;
    applyStimulus("half_st", 1'b0, 1'b1, 32'h017, 32'h1234BEEF, 4'b1011, 3, 1, 1, 10'd5, 32'hBEEFF00D);

    $display("[TB] loads");
    mem[8] = 32'h8000F0FF;
    applyStimulus("ld_sb0", 1'b1, 1'b0, 32'h020, 32'h0, 4'b1001, 2, 1, 0, 10'd8, 32'hFFFFFFFF);
    applyStimulus("ld_uh2", 1'b1, 1'b0, 32'h022, 32'h0, 4'b0011, 2, 1, 0, 10'd8, 32'h00008000);
    applyStimulus("ld_sh2", 1'b1, 1'b0, 32'h022, 32'h0, 4'b1011, 2, 1, 0, 10'd8, 32'hFFFF8000);
    applyStimulus("ld_w", 1'b1, 1'b0, 32'h020, 32'h0, 4'b0111, 2, 1, 0, 10'd8, 32'h8000F0FF);
    applyStimulus("ld_ub1", 1'b1, 1'b0, 32'h021, 32'h0, 4'b0001, 2, 1, 0, 10'd8, 32'h000000F0);
    applyStimulus("ld_sb3", 1'b1, 1'b0, 32'h023, 32'h0, 4'b1001, 2, 1, 0, 10'd8, 32'hFFFFFF80);
    applyStimulus("ld_uh_odd", 1'b1, 1'b0, 32'h021, 32'h0, 4'b0011, 2, 1, 0, 10'd8, 32'h0000F0FF);
    applyStimulus("ld_w_alias", 1'b1, 1'b0, 32'h1023, 32'h0, 4'b1111, 2, 1, 0, 10'd8, 32'h8000F0FF);
    applyStimulus("ld_half_back", 1'b1, 1'b0, 32'h016, 32'h0, 4'b0011, 2, 1, 0, 10'd5, 32'h0000BEEF);

    $display("[TB] read+write together");
    applyStimulus("rw_both", 1'b1, 1'b1, 32'h030, 32'h12345678, 4'b0111, 2, 0, 1, 10'd12, 32'h12345678);
    checkOutput("rw_both_read_data", read_data, 32'h0000BEEF);
    checkOutput("rw_both_mem", mem[12], 32'h12345678);

    $display("[TB] reset during read-modify-write");
    mem[5] = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    weCount    = 0;
    memwrite   = 1'b1;
    addr       = 32'h014;
    write_data = 32'h00005555;
    sign_mask  = 4'b0011;
    @(negedge clk);
    checkOutput("rmw_rst_stall_idle", {31'b0, clk_stall}, 32'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rmw_rst_stall_forced", {31'b0, clk_stall}, 32'h0);
    checkOutput("rmw_rst_we_forced", {31'b0, mem_we}, 32'h0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    memwrite = 1'b0;
    @(negedge clk);
    checkOutput("rmw_rst_stall_after", {31'b0, clk_stall}, 32'h0);
    checkOutput("rmw_rst_read_data", read_data, 32'h0);
    repeat (3) @(negedge clk);
    checkOutput("rmw_rst_we_count", weCount, 0);
    checkOutput("rmw_rst_mem", mem[5], 32'hCAFEF00D);
    applyStimulus("ld_after_rst", 1'b1, 1'b0, 32'h020, 32'h0, 4'b0111, 2, 1, 0, 10'd8, 32'h8000F0FF);

    repeat (2) @(negedge clk);
    checkOutput("wrq_drained", wrQ.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
